i2c_slave_rx: RTL
=================

// Module: i2c_slave_rx
// PURPOSE
//  I2C slave-receiver: the far end of the double-buffered master TX path. Samples SCL/SDA on clk,
//  detects START/STOP, matches a 7-bit address with the write bit, ACKs, and shifts data bytes
//  into ping-pong byte buffers RXBuf0/RXBuf1. A local consumer drains them with a valid/pop handshake.
//  A byte that arrives while both buffers are full is NACKed.
// PARAMETERS
//  SLAVE_ADDR  7'h50  7-bit address this block responds to
// PORTS
//  clk        in   1  system clock; must be >= 8x the SCL rate
//  rst_n      in   1  asynchronous, active-low reset
//  SCL        in   1  bus clock (raw, asynchronous)
//  SDA        in   1  bus data (raw, asynchronous)
//  SDAOutEn   out  1  1 = pull SDA low (open-drain ACK); 0 = release
//  RXValid    out  1  RXData holds an unread byte
//  RXData     out  8  oldest unread byte
//  RXPop      in   1  consumer takes RXData this cycle; ignored when RXValid=0
//  AddrMatch  out  1  high from address ACK until STOP or repeated START
//  StartDet   out  1  one-cycle pulse on each START or repeated START
//  StopDet    out  1  one-cycle pulse on STOP
//  Overrun    out  1  sticky; set when a byte is dropped; cleared only by reset
// BEHAVIOUR
//  Reset: all outputs 0; FSM=IDLE; both buffers empty; pointers and count 0; bit counter 0.
//  Input sync: 2-FF synchroniser on SCL and SDA, then a 1-cycle edge detector. Bus events are
//   seen 3 clk after the pin edge.
//  START = SDA falls while SCL high. STOP = SDA rises while SCL high. Both are honoured in every
//   state. START -> ADDR with bit count 0. STOP -> IDLE; SDAOutEn=0; AddrMatch=0.
//  Bits are sampled on SCL rising edges, MSB first, into an 8-bit shift register.
//  FSM:
//   IDLE:    wait for START.
//   ADDR:    8th SCL rise with shreg[7:1]==SLAVE_ADDR and bit0==0 -> ADDRACK; otherwise -> IGNORE.
//   ADDRACK: SDAOutEn=1 from the next SCL fall. Hold through the 9th SCL rise. On the following
//            SCL fall, SDAOutEn=0 and go to DATA. AddrMatch is set when entering ADDRACK.
//   DATA:    on the 8th SCL rise the byte is complete. If buffer count<2, write it to the buffer
//            at the write pointer (wptr toggles) and go to DACK. If count==2, drop the byte,
//            set Overrun and go to DNACK.
//   DACK:    same timing as ADDRACK, then back to DATA with bit count 0.
//   DNACK:   SDAOutEn stays 0 through the 9th clock, then -> IGNORE.
//   IGNORE:  SDAOutEn=0; wait for START or STOP.
//  Buffers: count 0..2; rptr and wptr are 1 bit each. RXValid = (count != 0).
//   RXData = RXBuf[rptr], combinational from the registers.
//  Pop with RXValid=1: rptr toggles, count-1. A store and a pop in the same cycle leave count
//   unchanged and both pointers toggle. A pop with RXValid=0 has no effect.
//  Latency: a byte is visible on RXValid/RXData 1 clk after the registered 8th SCL rise.
//  SDAOutEn changes only while SCL is low, except for the forced release on STOP.
//  A repeated START mid-byte discards the partial byte; buffered bytes are kept.
//  Reset asserted mid-transfer: immediate return to reset values, including SDAOutEn=0.
// TESTING
//  1. START, addr 0x50+W, data 0xA5, STOP -> ACK on both 9th clocks; RXValid=1, RXData=0xA5;
//     StartDet and StopDet pulse once each.
//  2. START, addr 0x51+W -> no ACK, stays in IGNORE; a following 0xFF byte is not stored;
//     RXValid stays 0.
//  3. Three bytes 0x11,0x22,0x33 with no pops -> 0x11 and 0x22 ACKed, 0x33 NACKed;
//     Overrun=1; pops return 0x11 then 0x22.
//  4. Pop asserted in the same cycle 0x22 is stored (count 1) -> count stays 1;
//     RXData=0x22 next cycle.
//  5. Repeated START after 4 bits of a byte, then addr 0x50+W and 0x7E -> only 0x7E is stored;
//     StartDet pulses twice.
//  6. rst_n low while SDAOutEn=1 during ACK -> SDAOutEn=0 and all outputs 0 in the same cycle;
//     FSM=IDLE.

Source files
------------

// File: rtl/i2c_slave_rx.sv
// I2C slave receiver: synchronises SCL/SDA, matches a 7-bit write address, ACKs,
// and parks received bytes in a two-entry ping-pong buffer drained by valid/pop.
module i2c_slave_rx #(
   parameter logic [6:0] SLAVE_ADDR = 7'h50
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       SCL,
   input  logic       SDA,
   output logic       SDAOutEn,
   output logic       RXValid,
   output logic [7:0] RXData,
   input  logic       RXPop,
   output logic       AddrMatch,
   output logic       StartDet,
   output logic       StopDet,
   output logic       Overrun
);

   localparam int unsigned BYTE_W = 8;
   localparam int unsigned BIT_W  = 3;
   localparam int unsigned CNT_W  = 2;

   typedef enum logic [2:0] {
      S_IDLE, S_ADDR, S_ADDRACK, S_DATA, S_DACK, S_DNACK, S_IGNORE
   } state_t;

   state_t state, state_n;

   logic [1:0]        scl_sync, sda_sync;
   logic              scl_q, sda_q;
   logic              scl_s, sda_s;
   logic              scl_rise, scl_fall, start_c, stop_c;

   logic [BIT_W-1:0]  bitcnt, bitcnt_n;
   logic [BYTE_W-2:0] shreg, shreg_n;
   logic [BYTE_W-1:0] byte_c;
   logic              ack9, ack9_n;
   logic              oe_n, match_n, start_n, stop_n, ovr_n;
   logic              store_c, pop_c;

   logic [1:0][BYTE_W-1:0] rx_buf;
   logic                   rptr, wptr;
   logic [CNT_W-1:0]       count, count_n;

   // Two-flop synchronisers plus one delayed copy for edge detection; idle bus is high
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         scl_sync <= 2'b11;
         sda_sync <= 2'b11;
         scl_q    <= 1'b1;
         sda_q    <= 1'b1;
      end else begin
         scl_sync <= {scl_sync[0], SCL};
         sda_sync <= {sda_sync[0], SDA};
         scl_q    <= scl_sync[1];
         sda_q    <= sda_sync[1];
      end
   end

   assign scl_s    = scl_sync[1];
   assign sda_s    = sda_sync[1];
   assign scl_rise = scl_s & ~scl_q;
   assign scl_fall = ~scl_s & scl_q;
   assign start_c  = scl_s & scl_q & sda_q & ~sda_s;
   assign stop_c   = scl_s & scl_q & ~sda_q & sda_s;
   assign byte_c   = {shreg, sda_s};

   assign RXValid = (count != CNT_W'(0));
   assign RXData  = rx_buf[rptr];
   assign pop_c   = RXPop & RXValid;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= S_IDLE;
      else        state <= state_n;
   end

   // Next-state and next-output logic; START/STOP override every state
   always_comb begin
      state_n  = state;
      bitcnt_n = bitcnt;
      shreg_n  = shreg;
      ack9_n   = ack9;
      oe_n     = SDAOutEn;
      match_n  = AddrMatch;
      ovr_n    = Overrun;
      start_n  = 1'b0;
      stop_n   = 1'b0;
      store_c  = 1'b0;
      if (start_c) begin
         state_n  = S_ADDR;
         bitcnt_n = '0;
         oe_n     = 1'b0;
         match_n  = 1'b0;
         start_n  = 1'b1;
      end else if (stop_c) begin
         state_n = S_IDLE;
         oe_n    = 1'b0;
         match_n = 1'b0;
         stop_n  = 1'b1;
      end else begin
         case (state)
            S_IDLE: ;
            S_ADDR: begin
               if (scl_rise) begin
                  shreg_n = byte_c[BYTE_W-2:0];
                  if (bitcnt == BIT_W'(7)) begin
                     bitcnt_n = '0;
                     ack9_n   = 1'b0;
                     if (byte_c[7:1] == SLAVE_ADDR && !byte_c[0]) begin
                        state_n = S_ADDRACK;
                        match_n = 1'b1;
                     end else begin
                        state_n = S_IGNORE;
                     end
                  end else begin
                     bitcnt_n = bitcnt + BIT_W'(1);
                  end
               end
            end
            S_ADDRACK, S_DACK: begin
               // Drive low from the 8th fall, release on the 9th fall
               if (scl_fall) begin
                  if (!ack9) begin
                     oe_n = 1'b1;
                  end else begin
                     oe_n     = 1'b0;
                     state_n  = S_DATA;
                     bitcnt_n = '0;
                  end
               end else if (scl_rise) begin
                  ack9_n = 1'b1;
               end
            end
            S_DATA: begin
               if (scl_rise) begin
                  shreg_n = byte_c[BYTE_W-2:0];
                  if (bitcnt == BIT_W'(7)) begin
                     bitcnt_n = '0;
                     ack9_n   = 1'b0;
                     if (count != CNT_W'(2)) begin
                        store_c = 1'b1;
                        state_n = S_DACK;
                     end else begin
                        ovr_n   = 1'b1;
                        state_n = S_DNACK;
                     end
                  end else begin
                     bitcnt_n = bitcnt + BIT_W'(1);
                  end
               end
            end
            S_DNACK: begin
               if (scl_rise)              ack9_n  = 1'b1;
               else if (scl_fall && ack9) state_n = S_IGNORE;
            end
            S_IGNORE: oe_n = 1'b0;
            default:  state_n = S_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bitcnt    <= '0;
         shreg     <= '0;
         ack9      <= 1'b0;
         SDAOutEn  <= 1'b0;
         AddrMatch <= 1'b0;
         StartDet  <= 1'b0;
         StopDet   <= 1'b0;
         Overrun   <= 1'b0;
      end else begin
         bitcnt    <= bitcnt_n;
         shreg     <= shreg_n;
         ack9      <= ack9_n;
         SDAOutEn  <= oe_n;
         AddrMatch <= match_n;
         StartDet  <= start_n;
         StopDet   <= stop_n;
         Overrun   <= ovr_n;
      end
   end

   // Ping-pong buffer: simultaneous store and pop leave the count unchanged
   always_comb begin
      count_n = count;
      case ({store_c, pop_c})
         2'b10:   count_n = count + CNT_W'(1);
         2'b01:   count_n = count - CNT_W'(1);
         default: count_n = count;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rx_buf <= '0;
         rptr   <= 1'b0;
         wptr   <= 1'b0;
         count  <= '0;
      end else begin
         if (store_c) begin
            rx_buf[wptr] <= byte_c;
            wptr         <= ~wptr;
         end
         if (pop_c) rptr <= ~rptr;
         count <= count_n;
      end
   end

endmodule
